// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared definitions for the calculator datapath: ALU opcodes,
//               sequencer state encoding, ALU error code names and the
//               frustum program step record.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

   // ALU opcodes
   localparam logic [3:0] OP_NOP   = 4'b0000;
   localparam logic [3:0] OP_MUL   = 4'b0011;
   localparam logic [3:0] OP_ADD   = 4'b0100;
   localparam logic [3:0] OP_RESET = 4'b1100;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // ALU error codes; only OK carries meaning inside the sequencer
   typedef enum logic [1:0] {
      ERR_OK     = 2'b00,
      ERR_CODE_1 = 2'b01,
      ERR_CODE_2 = 2'b10,
      ERR_CODE_3 = 2'b11
   } err_e;

   // Operand source selects
   typedef enum logic [2:0] {
      SRC_ZERO = 3'd0,
      SRC_R1   = 3'd1,
      SRC_R2   = 3'd2,
      SRC_H    = 3'd3,
      SRC_T0   = 3'd4,
      SRC_T1   = 3'd5
   } src_e;

   // Destination selects
   typedef enum logic [1:0] {
      DST_T0  = 2'd0,
      DST_T1  = 2'd1,
      DST_RES = 2'd2
   } dst_e;

   typedef struct packed {
      logic [3:0] op;
      src_e       src_a;
      src_e       src_b;
      dst_e       dst;
   } step_t;

   localparam logic [2:0] LAST_STEP = 3'd5;

   function automatic logic [31:0] pick_operand(
      input src_e        sel,
      input logic [31:0] r1,
      input logic [31:0] r2,
      input logic [31:0] h,
      input logic [31:0] t0,
      input logic [31:0] t1
   );
      case (sel)
         SRC_R1:  return r1;
         SRC_R2:  return r2;
         SRC_H:   return h;
         SRC_T0:  return t0;
         SRC_T1:  return t1;
         default: return 32'd0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/frustum_step_rom.sv
`default_nettype none
// ============================================================================
// Module      : frustum_step_rom
// Description : Combinational program table for h*(r1^2 + r1*r2 + r2^2).
//               Maps a step index (0..5) to {opcode, src A, src B, dest}.
// Ports       : step  - program step index
//               entry - decoded step record
// Revision    : 1.0 - initial release
// ============================================================================
module frustum_step_rom
   import calc_pkg::*;
(
   input  logic [2:0] step,
   output step_t      entry
);

   always_comb begin
      entry = '{op: OP_NOP, src_a: SRC_ZERO, src_b: SRC_ZERO, dst: DST_T0};
      case (step)
         3'd0: entry = '{op: OP_MUL, src_a: SRC_R1, src_b: SRC_R1, dst: DST_T0};
         3'd1: entry = '{op: OP_MUL, src_a: SRC_R1, src_b: SRC_R2, dst: DST_T1};
         3'd2: entry = '{op: OP_ADD, src_a: SRC_T0, src_b: SRC_T1, dst: DST_T0};
         3'd3: entry = '{op: OP_MUL, src_a: SRC_R2, src_b: SRC_R2, dst: DST_T1};
         3'd4: entry = '{op: OP_ADD, src_a: SRC_T0, src_b: SRC_T1, dst: DST_T0};
         3'd5: entry = '{op: OP_MUL, src_a: SRC_H,  src_b: SRC_T0, dst: DST_RES};
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/frustum_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frustum_seq_ctrl
// Description : Drives the shared ALU through the six-step frustum volume
//               program behind a start/busy/done handshake, latching the
//               first ALU error and aborting the program on it.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               start, r1, r2, h    - request and operands (latched on accept)
//               busy, done          - program running / one-cycle completion
//               result, err, err_code - outcome, held until the next run
//               alu_a, alu_b, alu_op - ALU operands and opcode
//               alu_out, alu_err    - ALU result and error code
// Revision    : 1.0 - initial release
// ============================================================================
module frustum_seq_ctrl
   import calc_pkg::*;
#(
   parameter int unsigned ALU_LAT = 1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] r1,
   input  logic [31:0] r2,
   input  logic [31:0] h,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [31:0] alu_out,
   input  logic [1:0]  alu_err
);

   localparam int unsigned     WCW       = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   // WAIT lasts ALU_LAT cycles; the counter reaches zero on the capture cycle
   localparam logic [WCW-1:0]  WAIT_LOAD = WCW'(ALU_LAT - 1);

   state_e           state_q, state_d;
   logic [2:0]       step_q, step_d;
   logic [WCW-1:0]   wait_q, wait_d;
   logic [31:0]      r1_q, r1_d, r2_q, r2_d, h_q, h_d;
   logic [31:0]      t0_q, t0_d, t1_q, t1_d;
   logic [31:0]      result_q, result_d;
   logic             err_q, err_d;
   logic [1:0]       err_code_q, err_code_d;
   step_t            rom_entry;

   frustum_step_rom u_rom (
      .step  (step_q),
      .entry (rom_entry)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         step_q     <= '0;
         wait_q     <= '0;
         r1_q       <= '0;
         r2_q       <= '0;
         h_q        <= '0;
         t0_q       <= '0;
         t1_q       <= '0;
         result_q   <= '0;
         err_q      <= 1'b0;
         err_code_q <= ERR_OK;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         wait_q     <= wait_d;
         r1_q       <= r1_d;
         r2_q       <= r2_d;
         h_q        <= h_d;
         t0_q       <= t0_d;
         t1_q       <= t1_d;
         result_q   <= result_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      wait_d     = wait_q;
      r1_d       = r1_q;
      r2_d       = r2_q;
      h_d        = h_q;
      t0_d       = t0_q;
      t1_d       = t1_q;
      result_d   = result_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               r1_d       = r1;
               r2_d       = r2;
               h_d        = h;
               err_d      = 1'b0;
               err_code_d = ERR_OK;
               step_d     = '0;
               state_d    = ST_CLR;
            end
         end
         ST_CLR:   state_d = ST_ISSUE;
         ST_ISSUE: begin
            wait_d  = WAIT_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_q != '0) begin
               wait_d = wait_q - WCW'(1);
            end else if (alu_err != ERR_OK) begin
               // abort: report the error with a cleared result
               err_d      = 1'b1;
               err_code_d = alu_err;
               result_d   = '0;
               state_d    = ST_DONE;
            end else begin
               case (rom_entry.dst)
                  DST_T0:  t0_d     = alu_out;
                  DST_T1:  t1_d     = alu_out;
                  DST_RES: result_d = alu_out;
                  default: ;
               endcase
               if (step_q == LAST_STEP) begin
                  state_d = ST_DONE;
               end else begin
                  step_d  = step_q + 3'd1;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ALU drive: operands are held through WAIT so a multi-cycle ALU sees
   // stable inputs until the capture cycle.
   always_comb begin
      alu_op = OP_NOP;
      alu_a  = '0;
      alu_b  = '0;
      case (state_q)
         ST_CLR: alu_op = OP_RESET;
         ST_ISSUE, ST_WAIT: begin
            alu_op = rom_entry.op;
            alu_a  = pick_operand(rom_entry.src_a, r1_q, r2_q, h_q, t0_q, t1_q);
            alu_b  = pick_operand(rom_entry.src_b, r1_q, r2_q, h_q, t0_q, t1_q);
         end
         default: ;
      endcase
   end

   assign busy     = (state_q == ST_CLR) || (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign done     = (state_q == ST_DONE);
   assign result   = result_q;
   assign err      = err_q;
   assign err_code = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_frustum_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_frustum_seq_ctrl
// Description : Self-checking bench. Two sequencers (ALU latency 1 and 3)
//               share the request inputs, each driving its own ALU stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frustum_seq_ctrl;
   import calc_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [31:0] r1, r2, h;

   logic        busy_1, done_1, err_1, busy_3, done_3, err_3;
   logic [31:0] result_1, result_3, alu_a_1, alu_b_1, alu_a_3, alu_b_3;
   logic [1:0]  err_code_1, err_code_3;
   logic [3:0]  alu_op_1, alu_op_3;
   logic [31:0] alu_out_1, alu_out_3, pipe0_3, pipe1_3;
   logic [1:0]  alu_err_1, alu_err_3;
   logic        inj1 = 1'b0;

   always #5 clk = ~clk;

   frustum_seq_ctrl #(.ALU_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .r1(r1), .r2(r2), .h(h),
      .busy(busy_1), .done(done_1), .result(result_1), .err(err_1),
      .err_code(err_code_1), .alu_a(alu_a_1), .alu_b(alu_b_1),
      .alu_op(alu_op_1), .alu_out(alu_out_1), .alu_err(alu_err_1)
   );

   frustum_seq_ctrl #(.ALU_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .start(start), .r1(r1), .r2(r2), .h(h),
      .busy(busy_3), .done(done_3), .result(result_3), .err(err_3),
      .err_code(err_code_3), .alu_a(alu_a_3), .alu_b(alu_b_3),
      .alu_op(alu_op_3), .alu_out(alu_out_3), .alu_err(alu_err_3)
   );

   // ALU stubs: result appears ALU_LAT edges after the inputs are presented
   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op == OP_MUL) return a * b;
      if (op == OP_ADD) return a + b;
      return 32'd0;
   endfunction

   always @(posedge clk) begin
      alu_out_1 <= alu_f(alu_op_1, alu_a_1, alu_b_1);
      alu_err_1 <= (inj1 && alu_op_1 == OP_ADD) ? 2'b01 : 2'b00;
      pipe0_3   <= alu_f(alu_op_3, alu_a_3, alu_b_3);
      pipe1_3   <= pipe0_3;
      alu_out_3 <= pipe1_3;
   end
   assign alu_err_3 = 2'b00;

   // Reference: frustum core computed directly, wrapped to 32 bits
   function automatic logic [31:0] ref_vol(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      longint unsigned x, y, z;
      x = a; y = b; z = c;
      return 32'((z * (x * x + x * y + y * y)) & 64'hFFFF_FFFF);
   endfunction

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Per-run observations
   int          d1, d3, ndone1;
   logic [31:0] res1, res3;
   logic        e1, e3;
   logic [1:0]  ec1;
   logic [3:0]  op_log [0:40];
   logic        busy_log [0:40];

   // Present a request sampled at edge k; log cycles k+1.. at negedges
   task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input bit hold, input bit perturb);
      @(negedge clk);
      r1 = a; r2 = b; h = c; start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      d1 = -1; d3 = -1; ndone1 = 0;
      res1 = 'x; res3 = 'x; e1 = 1'bx; e3 = 1'bx; ec1 = 'x;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         op_log[n]   = alu_op_1;
         busy_log[n] = busy_1;
         if (perturb && n == 5) r1 = ~a;
         if (done_1) begin
            ndone1++;
            if (d1 < 0) begin d1 = n; res1 = result_1; e1 = err_1; ec1 = err_code_1; end
         end
         if (done_3 && d3 < 0) begin d3 = n; res3 = result_3; e3 = err_3; end
         if (d1 >= 0 && d3 >= 0) break;
      end
   endtask

   task automatic check_normal(input string tag, input logic [31:0] exp);
      logic [3:0] exp_ops [0:5];
      bit ok;
      exp_ops = '{OP_MUL, OP_MUL, OP_ADD, OP_MUL, OP_ADD, OP_MUL};
      check({tag, " lat1 done cycle"}, 32'(d1), 32'd14);
      check({tag, " lat1 result"}, res1, exp);
      check({tag, " lat1 err"}, {31'd0, e1}, 32'd0);
      check({tag, " lat3 done cycle"}, 32'(d3), 32'd26);
      check({tag, " lat3 result"}, res3, exp);
      check({tag, " lat3 err"}, {31'd0, e3}, 32'd0);
      ok = 1'b1;
      for (int n = 1; n <= 13; n++) if (busy_log[n] !== 1'b1) ok = 1'b0;
      if (busy_log[14] !== 1'b0) ok = 1'b0;
      check({tag, " busy window"}, {31'd0, ok}, 32'd1);
      ok = (op_log[1] === OP_RESET);
      for (int i = 0; i < 6; i++)
         if (op_log[2+2*i] !== exp_ops[i] || op_log[3+2*i] !== exp_ops[i]) ok = 1'b0;
      check({tag, " op sequence"}, {31'd0, ok}, 32'd1);
   endtask

   typedef struct {
      logic [31:0] r1, r2, h, exp;
   } vec_t;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [0:5];
      logic [31:0] a, b, c;
      int cnt;
      bit ok;
      vecs[0] = '{32'd2, 32'd3, 32'd5, 32'd95};
      vecs[1] = '{32'd0, 32'd0, 32'd0, 32'd0};
      vecs[2] = '{32'd1, 32'd1, 32'd1, 32'd3};
      vecs[3] = '{32'd4, 32'd1, 32'd2, 32'd42};
      vecs[4] = '{32'hFFFF_FFFF, 32'd1, 32'd1, 32'd1};
      vecs[5] = '{32'd65536, 32'd1, 32'd3, 32'd196611};

      reset = 1'b1; start = 1'b0; r1 = '0; r2 = '0; h = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy", {31'd0, busy_1}, 32'd0);
      check("reset done", {31'd0, done_1}, 32'd0);
      check("reset result", result_1, 32'd0);
      check("reset err", {30'd0, err_1, err_3}, 32'd0);
      check("reset err_code", {30'd0, err_code_1}, 32'd0);
      check("reset alu_op", {28'd0, alu_op_1}, {28'd0, OP_NOP});
      check("reset alu_a/b", alu_a_1 | alu_b_1 | alu_a_3 | alu_b_3, 32'd0);
      reset = 1'b0;

      // Table vectors
      for (int i = 0; i < 6; i++) begin
         run(vecs[i].r1, vecs[i].r2, vecs[i].h, 1'b0, 1'b0);
         check_normal($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Randomized runs against the reference
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) begin
            a = $urandom_range(0, 1000); b = $urandom_range(0, 1000); c = $urandom_range(0, 1000);
         end else begin
            a = $urandom; b = $urandom; c = $urandom;
         end
         run(a, b, c, 1'b0, 1'b0);
         check_normal($sformatf("rand%0d", i), ref_vol(a, b, c));
      end

      // Error abort at step 2 on the latency-1 unit
      inj1 = 1'b1;
      run(32'd7, 32'd9, 32'd11, 1'b0, 1'b0);
      inj1 = 1'b0;
      check("abort done cycle", 32'(d1), 32'd8);
      check("abort err", {31'd0, e1}, 32'd1);
      check("abort err_code", {30'd0, ec1}, 32'd1);
      check("abort result", res1, 32'd0);
      ok = 1'b1;
      for (int n = 8; n <= 26; n++) if (op_log[n] !== OP_NOP) ok = 1'b0;
      check("abort no further ops", {31'd0, ok}, 32'd1);
      check("abort lat3 unaffected", res3, ref_vol(32'd7, 32'd9, 32'd11));

      // Errors are cleared on the next acceptance
      run(32'd3, 32'd2, 32'd1, 1'b0, 1'b0);
      check_normal("after abort", 32'd19);
      check("after abort err_code", {30'd0, ec1}, 32'd0);

      // Reset in cycle k+6
      @(negedge clk);
      r1 = 32'd5; r2 = 32'd6; h = 32'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 1; n <= 6; n++) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midreset busy/done", {28'd0, busy_1, done_1, busy_3, done_3}, 32'd0);
      check("midreset result", result_1 | result_3, 32'd0);
      check("midreset err", {29'd0, err_1, err_code_1}, 32'd0);
      check("midreset alu_op", {28'd0, alu_op_1}, {28'd0, OP_NOP});
      check("midreset alu_a/b", alu_a_1 | alu_b_1, 32'd0);
      reset = 1'b0;
      cnt = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (done_1 || done_3) cnt++;
      end
      check("midreset no done", 32'(cnt), 32'd0);
      run(32'd1, 32'd1, 32'd1, 1'b0, 1'b0);
      check_normal("post reset", 32'd3);

      // start held high, r1 changed mid-run
      run(32'd2, 32'd3, 32'd5, 1'b1, 1'b1);
      check("hold done cycle", 32'(d1), 32'd14);
      check("hold result", res1, 32'd95);
      check("hold single done", 32'(ndone1), 32'd1);
      check("hold idle gap", {30'd0, busy_log[15], busy_log[16]}, 32'd1);
      check("hold lat3 result", res3, 32'd95);
      @(negedge clk);
      start = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
